mem_controller: RTL and testbench



---
 rtl/mem_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_controller.sv
// Multi-channel memory arbiter: routes per-consumer read/write requests onto
// NUM_CHANNELS external memory ports, each channel running its own relay FSM.
module mem_controller #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]     consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDRESS_WIDTH-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]     consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                      mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                      mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      mem_read_data,
  output logic [NUM_CHANNELS-1:0]                      mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]      mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                      mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam bit WR_EN = (WRITE_ENABLE != 32'd0);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } chan_state_e;

  chan_state_e                 state_r      [NUM_CHANNELS];
  chan_state_e                 state_next_s [NUM_CHANNELS];
  logic [CW-1:0]               cons_idx_r      [NUM_CHANNELS];
  logic [CW-1:0]               cons_idx_next_s [NUM_CHANNELS];
  logic [CW-1:0]               pick_idx_s      [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]     pick_valid_s, pick_read_s;
  logic [NUM_CONSUMERS-1:0]    claim_r, claim_next_s, req_s;

  logic [NUM_CHANNELS-1:0]                     mem_read_valid_r, mem_read_valid_n;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_read_address_r, mem_read_address_n;
  logic [NUM_CHANNELS-1:0]                     mem_write_valid_r, mem_write_valid_n;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0]  mem_write_address_r, mem_write_address_n;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]     mem_write_data_r, mem_write_data_n;
  logic [NUM_CONSUMERS-1:0]                    consumer_read_ready_r, consumer_read_ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]    consumer_read_data_r, consumer_read_data_n;
  logic [NUM_CONSUMERS-1:0]                    consumer_write_ready_r, consumer_write_ready_n;

  // Write requests only count toward arbitration when the write path exists.
  assign req_s = consumer_read_valid | (WR_EN ? consumer_write_valid : {NUM_CONSUMERS{1'b0}});

  // Channel pick: ascending channel order, each sees claims taken by lower channels this cycle.
  always_comb begin : pick_comb
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found, hit, rd;
    logic [CW-1:0]            idx;
    taken = claim_r;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      found = 1'b0;
      rd    = 1'b0;
      idx   = {CW{1'b0}};
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        hit      = (state_r[ch] == IDLE) && !found && !taken[c] && req_s[c];
        idx      = hit ? CW'(c) : idx;
        rd       = hit ? consumer_read_valid[c] : rd;
        taken[c] = taken[c] | hit;
        found    = found | hit;
      end
      pick_valid_s[ch] = found;
      pick_read_s[ch]  = rd;
      pick_idx_s[ch]   = idx;
    end
  end

  // State, consumer index and claim mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      claim_r <= {NUM_CONSUMERS{1'b0}};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_r[ch]    <= IDLE;
        cons_idx_r[ch] <= {CW{1'b0}};
      end
    end else begin
      claim_r <= claim_next_s;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_r[ch]    <= state_next_s[ch];
        cons_idx_r[ch] <= cons_idx_next_s[ch];
      end
    end
  end

  // Next-state logic per channel, including claim set/release.
  always_comb begin
    claim_next_s = claim_r;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_next_s[ch]    = state_r[ch];
      cons_idx_next_s[ch] = cons_idx_r[ch];
      case (state_r[ch])
        IDLE: begin
          if (pick_valid_s[ch]) begin
            state_next_s[ch]               = pick_read_s[ch] ? READ_WAITING : WRITE_WAITING;
            cons_idx_next_s[ch]            = pick_idx_s[ch];
            claim_next_s[pick_idx_s[ch]]   = 1'b1;
          end else begin
            state_next_s[ch] = IDLE;
          end
        end
        READ_WAITING:  state_next_s[ch] = mem_read_ready[ch]  ? READ_RELAYING  : READ_WAITING;
        WRITE_WAITING: state_next_s[ch] = mem_write_ready[ch] ? WRITE_RELAYING : WRITE_WAITING;
        READ_RELAYING: begin
          if (!consumer_read_valid[cons_idx_r[ch]]) begin
            state_next_s[ch]             = IDLE;
            claim_next_s[cons_idx_r[ch]] = 1'b0;
          end else begin
            state_next_s[ch] = READ_RELAYING;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[cons_idx_r[ch]]) begin
            state_next_s[ch]             = IDLE;
            claim_next_s[cons_idx_r[ch]] = 1'b0;
          end else begin
            state_next_s[ch] = WRITE_RELAYING;
          end
        end
        default: state_next_s[ch] = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; unchanged fields hold their value.
  always_comb begin
    mem_read_valid_n       = mem_read_valid_r;
    mem_read_address_n     = mem_read_address_r;
    mem_write_valid_n      = mem_write_valid_r;
    mem_write_address_n    = mem_write_address_r;
    mem_write_data_n       = mem_write_data_r;
    consumer_read_ready_n  = consumer_read_ready_r;
    consumer_read_data_n   = consumer_read_data_r;
    consumer_write_ready_n = consumer_write_ready_r;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_r[ch])
        IDLE: begin
          if (pick_valid_s[ch] && pick_read_s[ch]) begin
            mem_read_valid_n[ch]   = 1'b1;
            mem_read_address_n[ch] = consumer_read_address[pick_idx_s[ch]];
          end else if (pick_valid_s[ch] && WR_EN) begin
            mem_write_valid_n[ch]   = 1'b1;
            mem_write_address_n[ch] = consumer_write_address[pick_idx_s[ch]];
            mem_write_data_n[ch]    = consumer_write_data[pick_idx_s[ch]];
          end else begin
            mem_read_valid_n[ch] = mem_read_valid_r[ch];
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            mem_read_valid_n[ch]                     = 1'b0;
            consumer_read_ready_n[cons_idx_r[ch]]    = 1'b1;
            consumer_read_data_n[cons_idx_r[ch]]     = mem_read_data[ch];
          end else begin
            mem_read_valid_n[ch] = mem_read_valid_r[ch];
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            mem_write_valid_n[ch]                  = 1'b0;
            consumer_write_ready_n[cons_idx_r[ch]] = 1'b1;
          end else begin
            mem_write_valid_n[ch] = mem_write_valid_r[ch];
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[cons_idx_r[ch]]) begin
            consumer_read_ready_n[cons_idx_r[ch]] = 1'b0;
          end else begin
            consumer_read_ready_n[cons_idx_r[ch]] = consumer_read_ready_r[cons_idx_r[ch]];
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[cons_idx_r[ch]]) begin
            consumer_write_ready_n[cons_idx_r[ch]] = 1'b0;
          end else begin
            consumer_write_ready_n[cons_idx_r[ch]] = consumer_write_ready_r[cons_idx_r[ch]];
          end
        end
        default: mem_read_valid_n[ch] = mem_read_valid_r[ch];
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_valid_r       <= {NUM_CHANNELS{1'b0}};
      mem_read_address_r     <= {(NUM_CHANNELS*ADDRESS_WIDTH){1'b0}};
      mem_write_valid_r      <= {NUM_CHANNELS{1'b0}};
      mem_write_address_r    <= {(NUM_CHANNELS*ADDRESS_WIDTH){1'b0}};
      mem_write_data_r       <= {(NUM_CHANNELS*DATA_WIDTH){1'b0}};
      consumer_read_ready_r  <= {NUM_CONSUMERS{1'b0}};
      consumer_read_data_r   <= {(NUM_CONSUMERS*DATA_WIDTH){1'b0}};
      consumer_write_ready_r <= {NUM_CONSUMERS{1'b0}};
    end else begin
      mem_read_valid_r       <= mem_read_valid_n;
      mem_read_address_r     <= mem_read_address_n;
      mem_write_valid_r      <= mem_write_valid_n;
      mem_write_address_r    <= mem_write_address_n;
      mem_write_data_r       <= mem_write_data_n;
      consumer_read_ready_r  <= consumer_read_ready_n;
      consumer_read_data_r   <= consumer_read_data_n;
      consumer_write_ready_r <= consumer_write_ready_n;
    end
  end

  assign mem_read_valid       = mem_read_valid_r;
  assign mem_read_address     = mem_read_address_r;
  assign mem_write_valid      = mem_write_valid_r;
  assign mem_write_address    = mem_write_address_r;
  assign mem_write_data       = mem_write_data_r;
  assign consumer_read_ready  = consumer_read_ready_r;
  assign consumer_read_data   = consumer_read_data_r;
  assign consumer_write_ready = consumer_write_ready_r;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: a 1-channel table run, reset abort,
// 2-channel contention and a read-only (WRITE_ENABLE=0) instance.
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Consumer-side stimulus is shared by all three instances.
  logic [3:0]        rv, wv;
  logic [3:0][7:0]   ra, wa;
  logic [3:0][15:0]  wd;

  // Instance A: 1 channel, read/write
  logic [0:0] a_mrr, a_mwr, a_mrv, a_mwv;
  logic [0:0][15:0] a_mrd, a_mwd;
  logic [0:0][7:0]  a_mra, a_mwa;
  logic [3:0] a_crr, a_cwr;
  logic [3:0][15:0] a_crd;

  // Instance B: 2 channels
  logic [1:0] b_mrr, b_mwr, b_mrv, b_mwv;
  logic [1:0][15:0] b_mrd, b_mwd;
  logic [1:0][7:0]  b_mra, b_mwa;
  logic [3:0] b_crr, b_cwr;
  logic [3:0][15:0] b_crd;

  // Instance R: 1 channel, read-only
  logic [0:0] r_mrr, r_mwr, r_mrv, r_mwv;
  logic [0:0][15:0] r_mrd, r_mwd;
  logic [0:0][7:0]  r_mra, r_mwa;
  logic [3:0] r_crr, r_cwr;
  logic [3:0][15:0] r_crd;

  mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra), .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa), .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra), .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_r (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(r_crr), .consumer_read_data(r_crd),
    .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd),
    .consumer_write_ready(r_cwr),
    .mem_read_valid(r_mrv), .mem_read_address(r_mra), .mem_read_ready(r_mrr), .mem_read_data(r_mrd),
    .mem_write_valid(r_mwv), .mem_write_address(r_mwa), .mem_write_data(r_mwd), .mem_write_ready(r_mwr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock edge, sample 1 time unit later; the read-only instance's
  // write outputs must be zero on every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    chk("ro_mem_write_valid",   {63'd0, r_mwv[0]}, 64'd0);
    chk("ro_mem_write_addr",    {56'd0, r_mwa[0]}, 64'd0);
    chk("ro_mem_write_data",    {48'd0, r_mwd[0]}, 64'd0);
    chk("ro_consumer_wr_ready", {60'd0, r_cwr},    64'd0);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_mrv"}, {63'd0, a_mrv[0]}, 64'd0);
    chk({tag, "_mra"}, {56'd0, a_mra[0]}, 64'd0);
    chk({tag, "_mwv"}, {63'd0, a_mwv[0]}, 64'd0);
    chk({tag, "_mwa"}, {56'd0, a_mwa[0]}, 64'd0);
    chk({tag, "_mwd"}, {48'd0, a_mwd[0]}, 64'd0);
    chk({tag, "_crr"}, {60'd0, a_crr},    64'd0);
    chk({tag, "_cwr"}, {60'd0, a_cwr},    64'd0);
    chk({tag, "_crd"}, a_crd,             64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv = 4'd0; wv = 4'd0;
    a_mrr = 1'b0; a_mwr = 1'b0; b_mrr = 2'd0; b_mwr = 2'd0; r_mrr = 1'b0; r_mwr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  rv, wv;
    logic        mrr;
    logic [15:0] mrd;
    logic        mwr;
    logic        e_mrv;
    logic [7:0]  e_mra;
    logic        e_mwv;
    logic [7:0]  e_mwa;
    logic [15:0] e_mwd;
    logic [3:0]  e_crr, e_cwr;
    int          crd_idx;
    logic [15:0] e_crd;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rv_i, logic [3:0] wv_i, logic mrr_i, logic [15:0] mrd_i,
                              logic mwr_i, logic mrv_e, logic [7:0] mra_e, logic mwv_e,
                              logic [7:0] mwa_e, logic [15:0] mwd_e, logic [3:0] crr_e,
                              logic [3:0] cwr_e, int idx, logic [15:0] crd_e);
    vec_t v;
    v.rv = rv_i; v.wv = wv_i; v.mrr = mrr_i; v.mrd = mrd_i; v.mwr = mwr_i;
    v.e_mrv = mrv_e; v.e_mra = mra_e; v.e_mwv = mwv_e; v.e_mwa = mwa_e; v.e_mwd = mwd_e;
    v.e_crr = crr_e; v.e_cwr = cwr_e; v.crd_idx = idx; v.e_crd = crd_e;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    // Fixed per-consumer addresses/data: c0 reads 0x12, c2 writes 0x55 to 0x30.
    ra = {8'h43, 8'h42, 8'h41, 8'h12};
    wa = {8'h63, 8'h30, 8'h61, 8'h60};
    wd = {16'h0077, 16'h0055, 16'h0066, 16'h0044};
    a_mrd = 16'h0000; b_mrd = {16'h0000, 16'h0000}; r_mrd = 16'h0000;

    //          rv     wv     mrr   mrd        mwr   mrv   mra     mwv   mwa     mwd        crr    cwr  idx crd
    tbl[0]  = mk(4'h1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0, 0, 16'h0000);
    tbl[1]  = mk(4'h1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0, 0, 16'h0000);
    tbl[2]  = mk(4'h1, 4'h0, 1'b1, 16'h0ABC, 1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 16'h0000, 4'h1, 4'h0, 0, 16'h0ABC);
    tbl[3]  = mk(4'h1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 16'h0000, 4'h1, 4'h0, 0, 16'h0ABC);
    tbl[4]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b0, 8'h00, 16'h0000, 4'h0, 4'h0, 0, 16'h0ABC);
    tbl[5]  = mk(4'h0, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b1, 8'h30, 16'h0055, 4'h0, 4'h0, 0, 16'h0ABC);
    tbl[6]  = mk(4'h0, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b1, 8'h30, 16'h0055, 4'h0, 4'h0, 0, 16'h0ABC);
    tbl[7]  = mk(4'h0, 4'h4, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h12, 1'b0, 8'h30, 16'h0055, 4'h0, 4'h4, 0, 16'h0ABC);
    tbl[8]  = mk(4'h0, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b0, 8'h30, 16'h0055, 4'h0, 4'h4, 0, 16'h0ABC);
    tbl[9]  = mk(4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h12, 1'b0, 8'h30, 16'h0055, 4'h0, 4'h0, 0, 16'h0ABC);
    tbl[10] = mk(4'h2, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h41, 1'b0, 8'h30, 16'h0055, 4'h0, 4'h0, 1, 16'h0000);
    tbl[11] = mk(4'h2, 4'h2, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h41, 1'b0, 8'h30, 16'h0055, 4'h2, 4'h0, 1, 16'h1234);
    tbl[12] = mk(4'h0, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h41, 1'b0, 8'h30, 16'h0055, 4'h0, 4'h0, 1, 16'h1234);
    tbl[13] = mk(4'h0, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h41, 1'b1, 8'h61, 16'h0066, 4'h0, 4'h0, 1, 16'h1234);
    tbl[14] = mk(4'h0, 4'h2, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h41, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h2, 1, 16'h1234);
    tbl[15] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h41, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h0, 1, 16'h1234);
    tbl[16] = mk(4'hC, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h42, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h0, 2, 16'h0000);
    tbl[17] = mk(4'hC, 4'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h42, 1'b0, 8'h61, 16'h0066, 4'h4, 4'h0, 2, 16'hBEEF);
    tbl[18] = mk(4'h8, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h42, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h0, 2, 16'hBEEF);
    tbl[19] = mk(4'h8, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h43, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h0, 3, 16'h0000);
    tbl[20] = mk(4'h8, 4'h0, 1'b1, 16'h00C3, 1'b0, 1'b0, 8'h43, 1'b0, 8'h61, 16'h0066, 4'h8, 4'h0, 3, 16'h00C3);
    tbl[21] = mk(4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h43, 1'b0, 8'h61, 16'h0066, 4'h0, 4'h0, 3, 16'h00C3);

    do_reset();
    chk_a_zero("reset");

    // Single-channel table
    for (int i = 0; i < 22; i++) begin
      rv = tbl[i].rv; wv = tbl[i].wv;
      a_mrr = tbl[i].mrr; a_mrd = tbl[i].mrd; a_mwr = tbl[i].mwr;
      step();
      chk($sformatf("row%0d_mrv", i), {63'd0, a_mrv[0]}, {63'd0, tbl[i].e_mrv});
      chk($sformatf("row%0d_mra", i), {56'd0, a_mra[0]}, {56'd0, tbl[i].e_mra});
      chk($sformatf("row%0d_mwv", i), {63'd0, a_mwv[0]}, {63'd0, tbl[i].e_mwv});
      chk($sformatf("row%0d_mwa", i), {56'd0, a_mwa[0]}, {56'd0, tbl[i].e_mwa});
      chk($sformatf("row%0d_mwd", i), {48'd0, a_mwd[0]}, {48'd0, tbl[i].e_mwd});
      chk($sformatf("row%0d_crr", i), {60'd0, a_crr},    {60'd0, tbl[i].e_crr});
      chk($sformatf("row%0d_cwr", i), {60'd0, a_cwr},    {60'd0, tbl[i].e_cwr});
      chk($sformatf("row%0d_crd", i), {48'd0, a_crd[tbl[i].crd_idx]}, {48'd0, tbl[i].e_crd});
    end

    // Reset while a read is waiting on memory, then a fresh read
    rv = 4'h1; a_mrr = 1'b0; a_mwr = 1'b0;
    step();
    chk("abort_pre_mrv", {63'd0, a_mrv[0]}, 64'd1);
    step();
    reset = 1'b1;
    step();
    chk_a_zero("abort");
    reset = 1'b0;
    step();
    chk("fresh_mrv", {63'd0, a_mrv[0]}, 64'd1);
    chk("fresh_mra", {56'd0, a_mra[0]}, 64'h12);
    ra[0] = 8'h99;
    step();
    chk("fresh_addr_held", {56'd0, a_mra[0]}, 64'h12);
    a_mrr = 1'b1; a_mrd = 16'h0F0F;
    step();
    chk("fresh_crr", {60'd0, a_crr}, 64'h1);
    chk("fresh_crd", {48'd0, a_crd[0]}, 64'h0F0F);
    chk("fresh_mrv_low", {63'd0, a_mrv[0]}, 64'd0);
    a_mrr = 1'b0; rv = 4'h0; ra[0] = 8'h12;
    step();
    chk("fresh_crr_low", {60'd0, a_crr}, 64'h0);

    // Two-channel contention across four consumers
    do_reset();
    rv = 4'hF;
    step();
    chk("cont_mrv_1", {62'd0, b_mrv}, 64'h3);
    chk("cont_mra0_1", {56'd0, b_mra[0]}, 64'h12);
    chk("cont_mra1_1", {56'd0, b_mra[1]}, 64'h41);
    b_mrr = 2'b01; b_mrd[0] = 16'hA000;
    step();
    chk("cont_crr_2", {60'd0, b_crr}, 64'h1);
    chk("cont_crd0_2", {48'd0, b_crd[0]}, 64'hA000);
    chk("cont_mrv_2", {62'd0, b_mrv}, 64'h2);
    b_mrr = 2'b00; rv = 4'hE;
    step();
    chk("cont_crr_3", {60'd0, b_crr}, 64'h0);
    chk("cont_mrv_3", {62'd0, b_mrv}, 64'h2);
    step();
    chk("cont_mrv_4", {62'd0, b_mrv}, 64'h3);
    chk("cont_mra0_4", {56'd0, b_mra[0]}, 64'h42);
    chk("cont_mra1_4", {56'd0, b_mra[1]}, 64'h41);
    b_mrr = 2'b10; b_mrd[1] = 16'hB001;
    step();
    chk("cont_crr_5", {60'd0, b_crr}, 64'h2);
    chk("cont_crd1_5", {48'd0, b_crd[1]}, 64'hB001);
    chk("cont_mrv_5", {62'd0, b_mrv}, 64'h1);
    b_mrr = 2'b00; rv = 4'hC;
    step();
    chk("cont_crr_6", {60'd0, b_crr}, 64'h0);
    step();
    chk("cont_mrv_7", {62'd0, b_mrv}, 64'h3);
    chk("cont_mra0_7", {56'd0, b_mra[0]}, 64'h42);
    chk("cont_mra1_7", {56'd0, b_mra[1]}, 64'h43);
    b_mrr = 2'b11; b_mrd = {16'hC003, 16'hC002};
    step();
    chk("cont_crr_8", {60'd0, b_crr}, 64'hC);
    chk("cont_crd2_8", {48'd0, b_crd[2]}, 64'hC002);
    chk("cont_crd3_8", {48'd0, b_crd[3]}, 64'hC003);
    b_mrr = 2'b00; rv = 4'h0;
    step();
    chk("cont_crr_9", {60'd0, b_crr}, 64'h0);

    // Read-only instance: write requests never claim, reads still work
    do_reset();
    wv = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ro_idle_mrv%0d", i), {63'd0, r_mrv[0]}, 64'd0);
    end
    rv = 4'h1;
    step();
    chk("ro_mrv", {63'd0, r_mrv[0]}, 64'd1);
    chk("ro_mra", {56'd0, r_mra[0]}, 64'h12);
    r_mrr = 1'b1; r_mrd = 16'h7777;
    step();
    chk("ro_crr", {60'd0, r_crr}, 64'h1);
    chk("ro_crd", {48'd0, r_crd[0]}, 64'h7777);
    r_mrr = 1'b0; rv = 4'h0; wv = 4'h0;
    step();
    chk("ro_crr_low", {60'd0, r_crr}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
